// File: rtl/sirv_pwm_capture.sv
// PWM input-capture peripheral.
// Samples an asynchronous PWM pin and measures the period (rise to rise) and
// high time (rise to fall) in prescaled clock ticks. The results sit behind a
// write_valid/write_bits/read register port. The block raises one interrupt
// for a completed capture or a counter overflow.
// Register handshake: io_regs_cfg_write_valid is a single-cycle strobe that is
// always accepted (there is no ready). write_bits is sampled on the same edge.
// The read ports are continuous views of the flops.
module sirv_pwm_capture #(
   parameter int CNT_W       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        io_pin,
   input  logic        io_regs_cfg_write_valid,
   input  logic [31:0] io_regs_cfg_write_bits,
   output logic [31:0] io_regs_cfg_read,
   output logic [31:0] io_regs_count_read,
   output logic [31:0] io_regs_period_read,
   output logic [31:0] io_regs_high_read,
   output logic        io_ip
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d_q;
   state_e                 state_q, state_d;
   logic [14:0]            pre_q, pre_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       high_tmp_q, high_tmp_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_q, high_d;
   logic [3:0]             scale_q, scale_d;
   logic                   en_q, en_d;
   logic                   oneshot_q, oneshot_d;
   logic                   invert_q, invert_d;
   logic                   ie_q, ie_d;
   logic                   ip_done_q, ip_done_d;
   logic                   ip_ovf_q, ip_ovf_d;

   logic                   s, rise, fall, tick;
   logic [14:0]            mask, pre_next;
   logic [CNT_W-1:0]       cnt_next;
   logic                   set_done, set_ovf, clr_en;
   logic                   cfg_we;
   logic [31:0]            wbits;

   assign cfg_we = io_regs_cfg_write_valid;
   assign wbits  = io_regs_cfg_write_bits;

   // Pin level after synchronisation and optional inversion; edges come from the last two samples.
   assign s    = sync_q[SYNC_STAGES-1] ^ invert_q;
   assign rise = s & ~s_d_q;
   assign fall = ~s & s_d_q;

   // The prescaler wraps when it reaches 2^scale-1. The counter saturates instead of wrapping.
   assign mask     = 15'((32'd1 << scale_q) - 32'd1);
   assign tick     = (pre_q == mask);
   assign pre_next = tick ? 15'd0 : pre_q + 15'd1;
   assign cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(tick);

   // Input synchroniser plus the one-cycle delayed level used for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], io_pin};
         s_d_q  <= s;
      end
   end

   // Measurement FSM next state. A cfg write that clears en overrides the FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pre_d      = pre_q;
      high_tmp_d = high_tmp_q;
      period_d   = period_q;
      high_d     = high_q;
      set_done   = 1'b0;
      set_ovf    = 1'b0;
      clr_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            pre_d = '0;
            if (en_q) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (rise) begin
               cnt_d   = '0;
               pre_d   = '0;
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            cnt_d = cnt_next;
            pre_d = pre_next;
            if (fall) begin
               high_tmp_d = cnt_next;
               state_d    = ST_LOW;
            end else if (cnt_next == CNT_MAX) begin
               set_ovf = 1'b1;
               state_d = ST_ARM;
            end
         end
         ST_LOW: begin
            cnt_d = cnt_next;
            pre_d = pre_next;
            if (rise) begin
               period_d = cnt_next;
               high_d   = high_tmp_q;
               set_done = 1'b1;
               cnt_d    = '0;
               pre_d    = '0;
               if (oneshot_q) begin
                  clr_en  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HIGH;
               end
            end else if (cnt_next == CNT_MAX) begin
               set_ovf = 1'b1;
               state_d = ST_ARM;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (cfg_we && !wbits[8]) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         pre_d   = '0;
      end
   end

   // Config fields load on a write. Hardware flag sets win over a same-cycle software clear.
   always_comb begin
      scale_d   = cfg_we ? wbits[3:0] : scale_q;
      en_d      = cfg_we ? wbits[8]   : en_q;
      oneshot_d = cfg_we ? wbits[9]   : oneshot_q;
      invert_d  = cfg_we ? wbits[10]  : invert_q;
      ie_d      = cfg_we ? wbits[12]  : ie_q;
      ip_done_d = set_done | (cfg_we ? wbits[28] : ip_done_q);
      ip_ovf_d  = set_ovf  | (cfg_we ? wbits[29] : ip_ovf_q);
      if (clr_en) en_d = 1'b0;
   end

   // State, measurement and config registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pre_q      <= '0;
         cnt_q      <= '0;
         high_tmp_q <= '0;
         period_q   <= '0;
         high_q     <= '0;
         scale_q    <= '0;
         en_q       <= 1'b0;
         oneshot_q  <= 1'b0;
         invert_q   <= 1'b0;
         ie_q       <= 1'b0;
         ip_done_q  <= 1'b0;
         ip_ovf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         high_tmp_q <= high_tmp_d;
         period_q   <= period_d;
         high_q     <= high_d;
         scale_q    <= scale_d;
         en_q       <= en_d;
         oneshot_q  <= oneshot_d;
         invert_q   <= invert_d;
         ie_q       <= ie_d;
         ip_done_q  <= ip_done_d;
         ip_ovf_q   <= ip_ovf_d;
      end
   end

   assign io_regs_cfg_read = {2'b00, ip_ovf_q, ip_done_q, 3'b000, s, 6'b000000,
                              state_q, 3'b000, ie_q, 1'b0, invert_q, oneshot_q,
                              en_q, 4'b0000, scale_q};
   assign io_regs_count_read  = 32'(cnt_q);
   assign io_regs_period_read = 32'(period_q);
   assign io_regs_high_read   = 32'(high_q);
   assign io_ip               = ie_q & (ip_done_q | ip_ovf_q);

endmodule

// File: tb/tb_sirv_pwm_capture.sv
// Directed bench for sirv_pwm_capture: a table of PWM waveforms with
// hand-computed captures, then sequences for overflow, one-shot, invert,
// disable mid-period, set/clear collision and reset mid-measurement.
module tb_sirv_pwm_capture;

   localparam logic [31:0] EN   = 32'h0000_0100;
   localparam logic [31:0] OS   = 32'h0000_0200;
   localparam logic [31:0] INV  = 32'h0000_0400;
   localparam logic [31:0] IE   = 32'h0000_1000;
   localparam logic [31:0] DONE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pin;
   logic        wv;
   logic [31:0] wbits;
   logic [31:0] cfg_r, cnt_r, per_r, hi_r;
   logic [31:0] cfg_r8, cnt_r8, per_r8, hi_r8;
   logic        ip, ip8;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0]  scale;
      logic        ie;
      int          period;
      int          high;
      logic [31:0] exp_period;
      logic [31:0] exp_high;
   } vec_t;

   vec_t vecs[5];

   sirv_pwm_capture dut (
      .clk(clk), .rst_n(rst_n), .io_pin(pin),
      .io_regs_cfg_write_valid(wv), .io_regs_cfg_write_bits(wbits),
      .io_regs_cfg_read(cfg_r), .io_regs_count_read(cnt_r),
      .io_regs_period_read(per_r), .io_regs_high_read(hi_r), .io_ip(ip)
   );

   sirv_pwm_capture #(.CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .io_pin(pin),
      .io_regs_cfg_write_valid(wv), .io_regs_cfg_write_bits(wbits),
      .io_regs_cfg_read(cfg_r8), .io_regs_count_read(cnt_r8),
      .io_regs_period_read(per_r8), .io_regs_high_read(hi_r8), .io_ip(ip8)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [31:0] data);
      wv    = 1'b1;
      wbits = data;
      tick(1);
      wv    = 1'b0;
      wbits = '0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{4'd0, 1'b1, 100, 30,  32'd100, 32'd30};
      vecs[1] = '{4'd3, 1'b0, 800, 200, 32'd100, 32'd25};
      vecs[2] = '{4'd0, 1'b1, 37,  1,   32'd37,  32'd1};
      vecs[3] = '{4'd1, 1'b0, 10,  4,   32'd5,   32'd2};
      vecs[4] = '{4'd2, 1'b1, 64,  63,  32'd16,  32'd15};

      rst_n = 1'b0;
      pin   = 1'b0;
      wv    = 1'b0;
      wbits = '0;
      tick(2);
      check("rst_cfg", cfg_r, 32'h0);
      check("rst_count", cnt_r, 32'h0);
      check("rst_period", per_r, 32'h0);
      check("rst_high", hi_r, 32'h0);
      check("rst_ip", {31'b0, ip}, 32'h0);
      rst_n = 1'b1;
      tick(2);

      cfg_write(EN);
      tick(1);
      check("arm_cfg", cfg_r, 32'h0001_0100);

      // Table of waveforms: arm on first rise, capture on the second.
      for (int i = 0; i < 5; i++) begin
         logic [31:0] c;
         c = EN | 32'(vecs[i].scale) | (vecs[i].ie ? IE : 32'h0);
         cfg_write(32'h0);
         pin = 1'b0;
         tick(4);
         cfg_write(c);
         tick(2);
         pin = 1'b1;
         tick(vecs[i].high);
         pin = 1'b0;
         tick(vecs[i].period - vecs[i].high);
         pin = 1'b1;
         tick(3);
         check($sformatf("v%0d_period", i), per_r, vecs[i].exp_period);
         check($sformatf("v%0d_high", i), hi_r, vecs[i].exp_high);
         check($sformatf("v%0d_done", i), {31'b0, cfg_r[28]}, 32'd1);
         check($sformatf("v%0d_ip", i), {31'b0, ip}, {31'b0, vecs[i].ie});
         if (vecs[i].ie) begin
            cfg_write(c);
            check($sformatf("v%0d_ip_clr", i), {31'b0, ip}, 32'd0);
            check($sformatf("v%0d_state_kept", i), {30'b0, cfg_r[17:16]}, 32'd2);
         end
      end

      // Overflow on the 8-bit instance; the 24-bit instance keeps counting.
      cfg_write(32'h0);
      pin = 1'b0;
      tick(4);
      cfg_write(EN);
      tick(2);
      pin = 1'b1;
      tick(300);
      check("ovf_flag", {31'b0, cfg_r8[29]}, 32'd1);
      check("ovf_state", {30'b0, cfg_r8[17:16]}, 32'd1);
      check("ovf_count", cnt_r8, 32'd255);
      check("ovf_period_kept", per_r8, 32'd16);
      check("ovf_high_kept", hi_r8, 32'd15);
      check("wide_count", cnt_r, 32'd297);
      check("wide_state", {30'b0, cfg_r[17:16]}, 32'd2);
      pin = 1'b0;
      tick(20);
      check("ovf_arm_hold", {30'b0, cfg_r8[17:16]}, 32'd1);
      check("ovf_period_hold", per_r8, 32'd16);

      // One-shot: a single capture, then en clears and later edges are ignored.
      cfg_write(32'h0);
      tick(4);
      cfg_write(EN | OS);
      tick(2);
      for (int k = 0; k < 4; k++) begin
         pin = 1'b1;
         tick(20);
         pin = 1'b0;
         tick(30);
      end
      pin = 1'b1;
      tick(10);
      check("os_period", per_r, 32'd50);
      check("os_high", hi_r, 32'd20);
      check("os_en", {31'b0, cfg_r[8]}, 32'd0);
      check("os_state", {30'b0, cfg_r[17:16]}, 32'd0);
      check("os_done", {31'b0, cfg_r[28]}, 32'd1);
      check("os_count", cnt_r, 32'd0);

      // Inverted input: pin low 30 / high 70.
      cfg_write(32'h0);
      tick(4);
      cfg_write(EN | INV);
      tick(2);
      pin = 1'b0;
      tick(30);
      pin = 1'b1;
      tick(70);
      pin = 1'b0;
      tick(3);
      check("inv_period", per_r, 32'd100);
      check("inv_high", hi_r, 32'd30);
      check("inv_level", {31'b0, cfg_r[24]}, 32'd1);

      // Disable mid-period: idle, counter cleared, captures kept.
      tick(10);
      cfg_write(INV | DONE);
      check("dis_state", {30'b0, cfg_r[17:16]}, 32'd0);
      check("dis_count", cnt_r, 32'd0);
      check("dis_period", per_r, 32'd100);
      check("dis_high", hi_r, 32'd30);
      check("dis_done", {31'b0, cfg_r[28]}, 32'd1);

      // Software clear colliding with a hardware set: the set wins.
      cfg_write(EN | INV);
      check("sw_clear_done", {31'b0, cfg_r[28]}, 32'd0);
      tick(2);
      pin = 1'b1;
      tick(20);
      pin = 1'b0;
      tick(30);
      pin = 1'b1;
      tick(20);
      pin = 1'b0;
      tick(2);
      wv    = 1'b1;
      wbits = EN | INV;
      tick(1);
      wv    = 1'b0;
      wbits = '0;
      check("coll_done", {31'b0, cfg_r[28]}, 32'd1);
      check("coll_period", per_r, 32'd50);
      check("coll_high", hi_r, 32'd30);
      check("coll_state", {30'b0, cfg_r[17:16]}, 32'd2);

      // Reset mid-measurement wipes everything.
      tick(5);
      rst_n = 1'b0;
      tick(2);
      check("mid_rst_cfg", cfg_r, 32'h0);
      check("mid_rst_period", per_r, 32'h0);
      check("mid_rst_high", hi_r, 32'h0);
      check("mid_rst_count", cnt_r, 32'h0);
      rst_n = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
